// File: rtl/uart_rx_oversampler_if.sv
// Byte handshake between the UART receiver and its consumer (RX FIFO write port).
// A byte moves on every cycle where valid && ready.
interface uart_rx_oversampler_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_oversampler.sv
// 8N1 UART receiver with a self-timed 16x oversample tick and 3-sample majority voting.
// Bytes are offered on a valid/ready port; frame and overrun errors are 1-cycle pulses.
module uart_rx_oversampler #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_i,
  uart_rx_oversampler_if.master        out_if,
  output logic                         frame_err_o,
  output logic                         overrun_o,
  output logic                         busy_o
);

  localparam int unsigned Div  = CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned PreW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(Div - 1);

  if (Div < 1) begin : gen_div_check
    $error("uart_rx_oversampler: CLK_FREQ too low for BAUD_RATE (divider < 1)");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q;
  logic            rx_meta_q, rxs_q;
  logic [PreW-1:0] pre_q;
  logic [3:0]      sc_q;
  logic [2:0]      bit_idx_q;
  logic [1:0]      samp_q;
  logic [7:0]      shift_q;
  logic            commit_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            frame_err_q, overrun_q, busy_q;

  logic os_tick, maj, eval, bit_end;

  always_comb begin
    os_tick = (state_q != StIdle) && (pre_q == PreMax);
    // samp_q holds the sc=7 and sc=8 samples; rxs_q is the sc=9 sample on the eval tick
    maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    eval    = os_tick && (sc_q == 4'd9);
    bit_end = os_tick && (sc_q == 4'd15);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pre_q       <= '0;
      sc_q        <= '0;
      bit_idx_q   <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      commit_q    <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      commit_q    <= 1'b0;

      if (state_q == StIdle) begin
        pre_q <= '0;
        sc_q  <= '0;
      end else if (os_tick) begin
        pre_q <= '0;
        sc_q  <= sc_q + 4'd1;
      end else begin
        pre_q <= pre_q + PreW'(1);
      end

      if (os_tick && (sc_q == 4'd7)) samp_q[0] <= rxs_q;
      if (os_tick && (sc_q == 4'd8)) samp_q[1] <= rxs_q;

      unique case (state_q)
        StIdle: begin
          if (!rxs_q) begin
            state_q <= StStart;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (eval && maj) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (bit_end) begin
            state_q   <= StData;
            bit_idx_q <= '0;
          end
        end
        StData: begin
          if (eval) shift_q <= {maj, shift_q[7:1]};
          if (bit_end) begin
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end
        end
        StStop: begin
          if (eval) begin
            if (maj) begin
              state_q  <= StIdle;
              busy_q   <= 1'b0;
              commit_q <= 1'b1;
            end else begin
              state_q     <= StBreak;
              frame_err_q <= 1'b1;
            end
          end
        end
        StBreak: begin
          if (rxs_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase

      // shift_q stays stable during the commit cycle: a new frame cannot reach its data bits yet
      if (commit_q) begin
        if (!valid_q || out_if.ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && out_if.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: directed and random rx waveforms checked every cycle against
// a line-level model (majority of fixed sample instants plus a handshake scoreboard).
module tb_uart_rx_oversampler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic frame_err, overrun, busy;

  uart_rx_oversampler_if rx_if ();

  uart_rx_oversampler #(
    .CLK_FREQ (3200000),
    .BAUD_RATE(100000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx),
    .out_if     (rx_if),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Model state: expectations for the current cycle, events keyed by absolute cycle
  logic [7:0] commit_sched[int];
  bit         fe_sched[int];
  bit         busy_sched[int];
  logic       ev = 1'b0, eov = 1'b0, efe = 1'b0, ebusy = 1'b0;
  logic [7:0] ed = 8'h00;

  int         n_valid = 0, n_fe = 0, n_ov = 0;
  int         valid_rise = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] got[$];
  int         ready_mode = 1;
  logic       wave[$];
  int         last_t0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Line bit bi is sampled at wave offsets 2 (sync) + DIV*(16*bi + sc), sc = 7, 8, 9, DIV = 2
  function automatic logic mbit(input int bi);
    return maj3(wave[32 * bi + 16], wave[32 * bi + 18], wave[32 * bi + 20]);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", rx_if.valid, 1'b0);
      check("rst_data", rx_if.data, 8'h00);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_busy", busy, 1'b0);
      ev = 1'b0; ed = 8'h00; eov = 1'b0; efe = 1'b0; ebusy = 1'b0;
      prev_valid = 1'b0;
    end else begin
      check("valid", rx_if.valid, ev);
      check("data", rx_if.data, ed);
      check("frame_err", frame_err, efe);
      check("overrun", overrun, eov);
      check("busy", busy, ebusy);
      check("err_exclusive", frame_err & overrun, 1'b0);
      if (rx_if.valid && rx_if.ready) got.push_back(rx_if.data);
      if (rx_if.valid && !prev_valid) valid_rise = cyc;
      prev_valid = rx_if.valid;
      n_valid += int'(rx_if.valid);
      n_fe += int'(frame_err);
      n_ov += int'(overrun);
      if (commit_sched.exists(cyc)) begin
        if (!ev || rx_if.ready) begin
          ed = commit_sched[cyc];
          ev = 1'b1;
          eov = 1'b0;
        end else begin
          eov = 1'b1;
        end
      end else begin
        eov = 1'b0;
        if (ev && rx_if.ready) ev = 1'b0;
      end
      efe = fe_sched.exists(cyc + 1);
      ebusy = busy_sched.exists(cyc + 1);
    end
  end

  initial begin
    rx_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 2) rx_if.ready = 1'($urandom_range(0, 1));
      else rx_if.ready = (ready_mode == 1);
    end
  end

  function automatic void build_frame(input logic [7:0] b, input bit stop, input int hold,
                                      input int gap);
    logic bits [10];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i + 1] = b[i];
    bits[9] = stop;
    wave.delete();
    for (int bi = 0; bi < 10; bi++) for (int c = 0; c < 32; c++) wave.push_back(bits[bi]);
    if (!stop) for (int i = 0; i < hold; i++) wave.push_back(1'b0);
    for (int i = 0; i < gap; i++) wave.push_back(1'b1);
  endfunction

  // Plays wave[] one sample per clk; wave[j] is captured by the DUT at edge t0+j
  task automatic run_wave(input int abort_j);
    int t0;
    logic [7:0] byte_v;
    @(posedge clk);
    #1;
    t0 = cyc + 1;
    last_t0 = t0;
    if (mbit(0)) begin
      for (int k = t0 + 2; k <= t0 + 21; k++) busy_sched[k] = 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) byte_v[i] = mbit(i + 1);
      if (mbit(9)) begin
        commit_sched[t0 + 310] = byte_v;
        for (int k = t0 + 2; k <= t0 + 309; k++) busy_sched[k] = 1'b1;
      end else begin
        int rel;
        fe_sched[t0 + 310] = 1'b1;
        rel = wave.size();
        for (int j = wave.size() - 1; j >= 309; j--) if (wave[j]) rel = j;
        for (int k = t0 + 2; k <= t0 + rel + 1; k++) busy_sched[k] = 1'b1;
      end
    end
    for (int j = 0; j < wave.size(); j++) begin
      if (j == abort_j) begin
        int now;
        rx = 1'b1;
        rst_n = 1'b0;
        now = cyc;
        foreach (busy_sched[k]) if (k >= now) busy_sched.delete(k);
        foreach (commit_sched[k]) if (k >= now) commit_sched.delete(k);
        foreach (fe_sched[k]) if (k >= now) fe_sched.delete(k);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        return;
      end
      rx = wave[j];
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int fe0, v0, ov0, gs;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 1: clean frame, always ready
    ready_mode = 1;
    v0 = n_valid; fe0 = n_fe; ov0 = n_ov;
    build_frame(8'h61, 1'b1, 0, 16);
    run_wave(-1);
    check("t1_valid_cycles", 32'(n_valid - v0), 32'd1);
    check("t1_byte", got[$], 8'h61);
    check("t1_valid_latency", 32'(valid_rise - last_t0), 32'd311);
    check("t1_no_errs", 32'(n_fe - fe0 + n_ov - ov0), 32'd0);
    check("t1_busy_end", busy, 1'b0);

    // 2: 8-clk glitch is a false start
    v0 = n_valid; fe0 = n_fe;
    wave.delete();
    for (int i = 0; i < 8; i++) wave.push_back(1'b0);
    for (int i = 0; i < 40; i++) wave.push_back(1'b1);
    run_wave(-1);
    check("t2_no_valid", 32'(n_valid - v0), 32'd0);
    check("t2_no_fe", 32'(n_fe - fe0), 32'd0);
    check("t2_busy", busy, 1'b0);

    // 3: bad stop bit, line held low, then a good frame
    v0 = n_valid; fe0 = n_fe;
    build_frame(8'h55, 1'b0, 100, 10);
    run_wave(-1);
    check("t3_one_fe", 32'(n_fe - fe0), 32'd1);
    check("t3_no_valid", 32'(n_valid - v0), 32'd0);
    build_frame(8'h41, 1'b1, 0, 10);
    run_wave(-1);
    check("t3_byte", got[$], 8'h41);

    // 4: consumer stalled, second byte overruns
    ready_mode = 0;
    ov0 = n_ov;
    build_frame(8'h12, 1'b1, 0, 10);
    run_wave(-1);
    build_frame(8'h34, 1'b1, 0, 10);
    run_wave(-1);
    check("t4_data_kept", rx_if.data, 8'h12);
    check("t4_valid_held", rx_if.valid, 1'b1);
    check("t4_one_overrun", 32'(n_ov - ov0), 32'd1);
    ready_mode = 1;
    @(posedge clk);
    #3;
    check("t4_consumed", rx_if.valid, 1'b0);
    check("t4_consumed_byte", got[$], 8'h12);

    // 5: one-cycle glitch on the middle sample of data bit 3
    fe0 = n_fe; ov0 = n_ov;
    build_frame(8'h00, 1'b1, 0, 10);
    wave[32 * 4 + 18] = 1'b1;
    run_wave(-1);
    check("t5_byte", got[$], 8'h00);
    check("t5_no_errs", 32'(n_fe - fe0 + n_ov - ov0), 32'd0);

    // 6: reset after data bit 4, then a fresh frame
    gs = got.size();
    fe0 = n_fe; ov0 = n_ov;
    build_frame(8'hC3, 1'b1, 0, 10);
    run_wave(32 * 6);
    build_frame(8'h7A, 1'b1, 0, 10);
    run_wave(-1);
    check("t6_one_byte", 32'(got.size() - gs), 32'd1);
    check("t6_byte", got[$], 8'h7A);
    check("t6_no_errs", 32'(n_fe - fe0 + n_ov - ov0), 32'd0);

    // Random frames, random ready, occasional bad stop bits and single-clk glitches
    ready_mode = 2;
    for (int n = 0; n < 16; n++) begin
      bit stop_v;
      stop_v = ($urandom_range(0, 4) != 0);
      build_frame(8'($urandom_range(0, 255)), stop_v, $urandom_range(0, 60),
                  $urandom_range(4, 40));
      if ($urandom_range(0, 1) == 1) begin
        int gj;
        gj = 32 * $urandom_range(1, 8) + $urandom_range(0, 31);
        wave[gj] = ~wave[gj];
      end
      run_wave(-1);
    end
    ready_mode = 1;
    repeat (4) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
